// File: rtl/mod_counter_sequencer_if.sv
// mod_counter_sequencer_if: bus between control logic (master) and the counter sequencer (slave).
// Carries the program-table write port, run control and the counter datapath handshake. Rev 1.0
`default_nettype none

interface mod_counter_sequencer_if #(
    parameter int ADDR_W = 2,
    parameter int REPS_W = 4
);
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [1:0]        cfg_mode;
    logic              cfg_dir;
    logic [REPS_W-1:0] cfg_reps;
    logic [ADDR_W-1:0] cfg_last;
    logic              start;
    logic              abort;
    logic              loop;
    logic [4:0]        cnt_val;
    logic [1:0]        cnt_mode;
    logic              cnt_dir;
    logic              cnt_clr;
    logic              cnt_en;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [ADDR_W-1:0] cur_entry;

    modport master (
        output cfg_we, cfg_addr, cfg_mode, cfg_dir, cfg_reps, cfg_last,
        output start, abort, loop, cnt_val,
        input  cnt_mode, cnt_dir, cnt_clr, cnt_en, busy, done, cfg_err, cur_entry
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_mode, cfg_dir, cfg_reps, cfg_last,
        input  start, abort, loop, cnt_val,
        output cnt_mode, cnt_dir, cnt_clr, cnt_en, busy, done, cfg_err, cur_entry
    );
endinterface

`default_nettype wire

// File: rtl/mod_counter_sequencer.sv
// mod_counter_sequencer: steps a small program table through the mod-2/8/10/16 counter.
// Build option MCS_LOOP_EN: restart the program from entry 0 while `loop` is high. Rev 1.0
`default_nettype none

module mod_counter_sequencer #(
    parameter int ADDR_W = 2,
    parameter int REPS_W = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mod_counter_sequencer_if.slave bus
);
    localparam int ENTRIES = 2 ** ADDR_W;

    typedef struct packed {
        logic [1:0]        mode;
        logic              dir;
        logic [REPS_W-1:0] reps;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              pend_q, pend_d;
    logic [REPS_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [REPS_W-1:0] reps_q, reps_d;
    logic [1:0]        mode_q, mode_d;
    logic              dir_q, dir_d;
    logic              cfg_err_q, cfg_err_d;

    entry_t            tbl_q [ENTRIES];
    entry_t            cur_w;
    logic              busy_w;
    logic              tbl_we_w;
    logic [4:0]        nm1_w;
    logic [4:0]        term_w;

    assign busy_w   = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_NEXT);
    assign tbl_we_w = bus.cfg_we && !busy_w;
    assign cur_w    = tbl_q[idx_q];

    // The table is storage only; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (tbl_we_w) begin
            tbl_q[bus.cfg_addr] <= '{mode: bus.cfg_mode, dir: bus.cfg_dir, reps: bus.cfg_reps};
        end
    end

    always_comb begin
        nm1_w = 5'd1;
        case (mode_q)
            2'b00:   nm1_w = 5'd1;
            2'b01:   nm1_w = 5'd7;
            2'b10:   nm1_w = 5'd9;
            default: nm1_w = 5'd15;
        endcase
        term_w = dir_q ? 5'd0 : nm1_w;
    end

    // pend_q marks that entry idx_q has not been evaluated yet; clear means it just finished.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        pend_d     = pend_q;
        wrap_cnt_d = wrap_cnt_q;
        reps_d     = reps_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        cfg_err_d  = bus.cfg_we && busy_w;

        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        last_d  = bus.cfg_last;
                        idx_d   = '0;
                        pend_d  = 1'b1;
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_NEXT: begin
                    if (pend_q && (cur_w.reps != '0)) begin
                        mode_d  = cur_w.mode;
                        dir_d   = cur_w.dir;
                        reps_d  = cur_w.reps;
                        pend_d  = 1'b0;
                        state_d = S_LOAD;
                    end else if (idx_q == last_q) begin
`ifdef MCS_LOOP_EN
                        if (bus.loop) begin
                            idx_d  = '0;
                            pend_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d  = idx_q + ADDR_W'(1);
                        pend_d = 1'b1;
                    end
                end
                S_LOAD: begin
                    wrap_cnt_d = '0;
                    state_d    = S_RUN;
                end
                S_RUN: begin
                    if (bus.cnt_val == term_w) begin
                        if (wrap_cnt_q == (reps_q - REPS_W'(1))) begin
                            state_d = S_NEXT;
                        end else begin
                            wrap_cnt_d = wrap_cnt_q + REPS_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_q     <= '0;
            pend_q     <= 1'b0;
            wrap_cnt_q <= '0;
            reps_q     <= '0;
            mode_q     <= 2'b00;
            dir_q      <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            wrap_cnt_q <= wrap_cnt_d;
            reps_q     <= reps_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifndef MCS_LOOP_EN
    logic unused_loop;
    assign unused_loop = bus.loop;
`endif

    assign bus.cnt_mode  = mode_q;
    assign bus.cnt_dir   = dir_q;
    assign bus.cnt_clr   = (state_q == S_LOAD);
    assign bus.cnt_en    = (state_q == S_RUN);
    assign bus.busy      = busy_w;
    assign bus.done      = (state_q == S_DONE);
    assign bus.cfg_err   = cfg_err_q;
    assign bus.cur_entry = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_sequencer.sv
// tb_mod_counter_sequencer: directed program runs against a behavioural modulo counter.
// Cycle k = k-th falling edge after the start edge; expected values are hand-derived.
`default_nettype none

module tb_mod_counter_sequencer;
    logic clk;
    logic reset;
    logic [4:0] m_cnt;

    int n_cmp, n_bad;
    int n_clr, n_en, n_done, n_err, n_busy;
    int clr_k1, clr_k2, done_k, err_k, ent_mask;
    int en_m [4];
    logic [2:0] post_abort;

    mod_counter_sequencer_if #(.ADDR_W(2), .REPS_W(4)) bus ();

    mod_counter_sequencer #(.ADDR_W(2), .REPS_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] nm1(input logic [1:0] mode);
        case (mode)
            2'b00:   return 5'd1;
            2'b01:   return 5'd7;
            2'b10:   return 5'd9;
            default: return 5'd15;
        endcase
    endfunction

    // Counter datapath driven by the sequencer outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) m_cnt <= 5'd0;
        else if (bus.cnt_clr) m_cnt <= bus.cnt_dir ? nm1(bus.cnt_mode) : 5'd0;
        else if (bus.cnt_en) begin
            if (bus.cnt_dir) m_cnt <= (m_cnt == 5'd0) ? nm1(bus.cnt_mode) : m_cnt - 5'd1;
            else             m_cnt <= (m_cnt == nm1(bus.cnt_mode)) ? 5'd0 : m_cnt + 5'd1;
        end
    end
    assign bus.cnt_val = m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr_entry(input logic [1:0] a, input logic [1:0] mode, input logic dir,
                            input logic [3:0] reps);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_mode = mode;
        bus.cfg_dir = dir; bus.cfg_reps = reps;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    // abort_k = 0 asserts abort together with start; we_k = write attempt cycle; loop high for k < loop_k.
    task automatic run_prog(input logic [1:0] last, input int win, input int abort_k,
                            input int we_k, input int loop_k);
        n_clr = 0; n_en = 0; n_done = 0; n_err = 0; n_busy = 0;
        clr_k1 = 0; clr_k2 = 0; done_k = 0; err_k = 0; ent_mask = 0;
        post_abort = 3'b111;
        for (int i = 0; i < 4; i++) en_m[i] = 0;
        @(negedge clk);
        bus.cfg_last = last;
        bus.start = 1'b1;
        bus.abort = (abort_k == 0);
        bus.loop  = (loop_k > 0);
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (bus.cnt_clr) begin
                n_clr++;
                if (n_clr == 1) clr_k1 = k;
                if (n_clr == 2) clr_k2 = k;
            end
            if (bus.cnt_en) begin
                n_en++;
                en_m[bus.cnt_mode]++;
                ent_mask = ent_mask | (1 << bus.cur_entry);
            end
            if (bus.done) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
            if (bus.cfg_err) begin
                n_err++;
                err_k = k;
            end
            if (bus.busy) n_busy++;
            if (k == abort_k + 1) post_abort = {bus.busy, bus.cnt_en, bus.cnt_clr};
            bus.start = 1'b0;
            bus.abort = (k == abort_k);
            bus.loop  = (k < loop_k);
            if (k == we_k) begin
                bus.cfg_addr = 2'd0; bus.cfg_mode = 2'b11;
                bus.cfg_dir = 1'b1; bus.cfg_reps = 4'd5;
            end
            bus.cfg_we = (k == we_k);
        end
        bus.abort = 1'b0;
        bus.cfg_we = 1'b0;
        bus.loop = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_mode = '0; bus.cfg_dir = 1'b0;
        bus.cfg_reps = '0; bus.cfg_last = '0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.loop = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {bus.busy, bus.done, bus.cnt_en, bus.cnt_clr, bus.cfg_err}, 0);
        check_eq("reset_cnt_cfg", {bus.cnt_mode, bus.cnt_dir, bus.cur_entry}, 0);
        reset = 1'b1;

        // T1: N=8 up, 2 wraps; NEXT, LOAD, 16 RUN, NEXT, then DONE in cycle 20
        wr_entry(2'd0, 2'b01, 1'b0, 4'd2);
        run_prog(2'd0, 26, -5, -1, 0);
        check_eq("t1_clr_cnt", n_clr, 1);
        check_eq("t1_clr_cycle", clr_k1, 2);
        check_eq("t1_en_cycles", en_m[1], 16);
        check_eq("t1_done_cycle", done_k, 20);
        check_eq("t1_done_width", n_done, 1);
        check_eq("t1_mode_held", {bus.cnt_mode, bus.cnt_dir}, 3'b010);

        // T2: N=2 down x3 then N=10 up x1
        wr_entry(2'd0, 2'b00, 1'b1, 4'd3);
        wr_entry(2'd1, 2'b10, 1'b0, 4'd1);
        run_prog(2'd1, 28, -5, -1, 0);
        check_eq("t2_run_mode0", en_m[0], 6);
        check_eq("t2_run_mode2", en_m[2], 10);
        check_eq("t2_load2_cycle", clr_k2, 11);
        check_eq("t2_done_cycle", done_k, 23);

        // T3: entry 0 skipped, entry 1 N=16 up x1
        wr_entry(2'd0, 2'b01, 1'b0, 4'd0);
        wr_entry(2'd1, 2'b11, 1'b0, 4'd1);
        run_prog(2'd1, 26, -5, -1, 0);
        check_eq("t3_loads", n_clr, 1);
        check_eq("t3_entry_mask", ent_mask, 2);
        check_eq("t3_en_cycles", en_m[3], 16);
        check_eq("t3_done_cycle", done_k, 21);

        // All entries up to last skipped: DONE without any LOAD
        run_prog(2'd0, 6, -5, -1, 0);
        check_eq("skip_all_loads", n_clr, 0);
        check_eq("skip_all_done", done_k, 2);

        // T4: abort on 8th RUN cycle, then rerun
        wr_entry(2'd0, 2'b01, 1'b0, 4'd2);
        run_prog(2'd0, 24, 10, -1, 0);
        check_eq("t4_post_abort", post_abort, 0);
        check_eq("t4_en_cycles", n_en, 8);
        check_eq("t4_no_done", n_done, 0);
        run_prog(2'd0, 26, -5, -1, 0);
        check_eq("t4_rerun_en", en_m[1], 16);
        check_eq("t4_rerun_done", done_k, 20);

        // start and abort together: abort wins
        run_prog(2'd0, 6, 0, -1, 0);
        check_eq("start_abort_busy", n_busy, 0);
        check_eq("start_abort_done", n_done, 0);

        // T5: write during RUN is dropped and flagged
        run_prog(2'd0, 26, -5, 5, 0);
        check_eq("t5_err_cycle", err_k, 6);
        check_eq("t5_err_width", n_err, 1);
        run_prog(2'd0, 26, -5, -1, 0);
        check_eq("t5_readback_en", en_m[1], 16);
        check_eq("t5_readback_done", done_k, 20);

`ifdef MCS_LOOP_EN
        // T6: second pass NEXT(19), NEXT(20), LOAD(21), RUN 22..37, NEXT 38, DONE 39
        run_prog(2'd0, 45, -5, -1, 25);
        check_eq("t6_loads", n_clr, 2);
        check_eq("t6_load2_cycle", clr_k2, 21);
        check_eq("t6_en_cycles", n_en, 32);
        check_eq("t6_done_cycle", done_k, 39);
        check_eq("t6_done_width", n_done, 1);
`else
        // loop is ignored: program ends normally
        run_prog(2'd0, 26, -5, -1, 30);
        check_eq("noloop_done_cycle", done_k, 20);
        check_eq("noloop_loads", n_clr, 1);
`endif

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_reset_en", bus.cnt_en, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_reset_outs",
                 {bus.busy, bus.cnt_en, bus.cnt_clr, bus.cnt_mode, bus.done}, 0);
        @(negedge clk);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
